// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (A=core, B=DMA/debug) data memory arbiter, 3-cycle IDLE/ACCESS/RESP access; define DMEM_ARB_ROUND_ROBIN_EN for round-robin contention (fixed A priority otherwise)
module dmem_arbiter #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic              b_req,
   input  logic              a_we,
   input  logic              b_we,
   input  logic [31:0]       a_addr,
   input  logic [31:0]       b_addr,
   input  logic [DATA_W-1:0] a_wdata,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              a_gnt,
   output logic              b_gnt,
   output logic              a_rvalid,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   output logic [DATA_W-1:0] b_rdata,
   output logic              a_err,
   output logic              b_err,
   output logic              mem_write,
   output logic              mem_read,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);
   state_t state, state_nxt;
   logic              start, pick_b, sel_b, we_q, in_range, acc, rsp;
   logic [31:0]       addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   assign start = (state == IDLE) && (a_req || b_req);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
   logic last_b;
   // last-granted pointer; starts at B so A wins the first contended request
   always_ff @(posedge clk or negedge reset)
      if (!reset) last_b <= 1'b1;
      else if (start) last_b <= pick_b;
   assign pick_b = b_req && (!a_req || !last_b);
`else
   assign pick_b = b_req && !a_req;
`endif
   // state register; async reset aborts any transaction in flight
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nxt;
   // winner's request is latched on entry to ACCESS, read data captured on entry to RESP
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         sel_b   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (start) begin
            sel_b   <= pick_b;
            we_q    <= pick_b ? b_we : a_we;
            addr_q  <= pick_b ? b_addr : a_addr;
            wdata_q <= pick_b ? b_wdata : a_wdata;
         end
         if (state == ACCESS) rdata_q <= mem_read ? mem_rdata : '0;
      end
   // next state and all outputs decoded from state; out-of-range accesses never strobe memory
   always_comb begin
      state_nxt = (state == IDLE) ? (start ? ACCESS : IDLE) : (state == ACCESS) ? RESP : IDLE;
      in_range  = addr_q < DEPTH_W;
      acc       = (state == ACCESS) && in_range;
      rsp       = state == RESP;
      a_gnt     = (state == ACCESS) && !sel_b;
      b_gnt     = (state == ACCESS) && sel_b;
      mem_write = acc && we_q;
      mem_read  = acc && !we_q;
      mem_addr  = acc ? addr_q : '0;
      mem_wdata = acc ? wdata_q : '0;
      a_rvalid  = rsp && !sel_b;
      b_rvalid  = rsp && sel_b;
      a_rdata   = a_rvalid ? rdata_q : '0;
      b_rdata   = b_rvalid ? rdata_q : '0;
      a_err     = a_rvalid && !in_range;
      b_err     = b_rvalid && !in_range;
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural memory model
module tb_dmem_arbiter;
   localparam int DW    = 32;
   localparam int DEPTH = 64;
   logic clk = 1'b0, reset = 1'b0;
   logic a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
   logic [31:0] a_addr = '0, b_addr = '0;
   logic [DW-1:0] a_wdata = '0, b_wdata = '0;
   logic a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, mem_write, mem_read;
   logic [DW-1:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
   logic [31:0] mem_addr;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   logic [3*DW+32+7:0] outs;
   typedef struct packed {logic [DW-1:0] rdata; logic err;} exp_t;
   exp_t aq[$], bq[$];
   exp_t ea, eb;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
      .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
      .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
      .a_rdata(a_rdata), .b_rdata(b_rdata), .a_err(a_err), .b_err(b_err),
      .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   assign outs = {a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, mem_write, mem_read,
                  mem_addr, mem_wdata, a_rdata, b_rdata};
   assign mem_rdata = mem_read ? mem[mem_addr[5:0]] : '0;
   always @(posedge clk) if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;

   always @(negedge clk) begin
      if (a_rvalid) begin
         checks++;
         if (aq.size() == 0) begin
            errors++;
            $display("FAIL a_unexpected_rvalid: got rdata=%h err=%b, required no response", a_rdata, a_err);
         end else begin
            ea = aq.pop_front();
            if ({a_rdata, a_err} !== ea || b_rvalid || b_rdata !== '0 || b_err) begin
               errors++;
               $display("FAIL a_resp: got rdata=%h err=%b (b_rvalid=%b b_rdata=%h b_err=%b), required rdata=%h err=%b with B idle",
                        a_rdata, a_err, b_rvalid, b_rdata, b_err, ea.rdata, ea.err);
            end
         end
      end
      if (b_rvalid) begin
         checks++;
         if (bq.size() == 0) begin
            errors++;
            $display("FAIL b_unexpected_rvalid: got rdata=%h err=%b, required no response", b_rdata, b_err);
         end else begin
            eb = bq.pop_front();
            if ({b_rdata, b_err} !== eb || a_rvalid || a_rdata !== '0 || a_err) begin
               errors++;
               $display("FAIL b_resp: got rdata=%h err=%b (a_rvalid=%b a_rdata=%h a_err=%b), required rdata=%h err=%b with A idle",
                        b_rdata, b_err, a_rvalid, a_rdata, a_err, eb.rdata, eb.err);
            end
         end
      end
   end

   task automatic push_exp(input bit port, input logic we, input logic [31:0] addr, input logic [DW-1:0] wd);
      exp_t e;
      e.err   = addr >= DEPTH;
      e.rdata = (we || e.err) ? '0 : ref_mem[addr[5:0]];
      if (we && !e.err) ref_mem[addr[5:0]] = wd;
      if (port) bq.push_back(e);
      else aq.push_back(e);
   endtask

   task automatic drive(input bit port, input logic we, input logic [31:0] addr, input logic [DW-1:0] wd);
      if (port) begin
         b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
      end else begin
         a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
      end
      push_exp(port, we, addr, wd);
   endtask

   task automatic wait_gnt(input bit port, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(port ? b_gnt : a_gnt) && n < 20);
      checks++;
      if (!(port ? b_gnt : a_gnt)) begin
         errors++;
         $display("FAIL %s_gnt_timeout: gnt=0 after %0d cycles, required 1", name, n);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((aq.size() != 0 || bq.size() != 0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checks++;
      if (aq.size() != 0 || bq.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d/%0d responses outstanding, required 0/0", name, aq.size(), bq.size());
         aq.delete();
         bq.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, required 0", outs);
      end
      drive(0, 1'b0, 32'd1, '0);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_sample: got a_gnt=%b b_gnt=%b, required 1 0", a_gnt, b_gnt);
      end
      a_req = 1'b0;
      drain("reset");
   endtask

   task automatic test_write_read();
      drive(0, 1'b1, 32'd5, 32'hDEADBEEF);
      wait_gnt(0, "wr");
      checks++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'd5 || mem_wdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wr_strobe: got we=%b re=%b addr=%h wdata=%h, required 1 0 00000005 deadbeef",
                  mem_write, mem_read, mem_addr, mem_wdata);
      end
      a_req = 1'b0;
      drain("wr");
      drive(0, 1'b0, 32'd5, '0);
      wait_gnt(0, "rd");
      checks++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'd5) begin
         errors++;
         $display("FAIL rd_strobe: got re=%b we=%b addr=%h, required 1 0 00000005", mem_read, mem_write, mem_addr);
      end
      a_req = 1'b0;
      drain("rd");
   endtask

   task automatic test_out_of_range();
      drive(1, 1'b0, 32'd70, '0);
      wait_gnt(1, "oor");
      checks++;
      if (b_gnt !== 1'b1 || a_gnt !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== '0) begin
         errors++;
         $display("FAIL oor_access: got b_gnt=%b a_gnt=%b re=%b we=%b addr=%h, required 1 0 0 0 0",
                  b_gnt, a_gnt, mem_read, mem_write, mem_addr);
      end
      b_req = 1'b0;
      @(negedge clk);
      checks++;
      if (b_rvalid !== 1'b1 || b_err !== 1'b1 || mem_read !== 1'b0) begin
         errors++;
         $display("FAIL oor_resp: got b_rvalid=%b b_err=%b re=%b, required 1 1 0", b_rvalid, b_err, mem_read);
      end
      drain("oor");
   endtask

   task automatic test_latency();
      drive(0, 1'b0, 32'd5, '0);
      checks++;
      if (a_gnt !== 1'b0) begin
         errors++;
         $display("FAIL lat_n: got a_gnt=%b, required 0", a_gnt);
      end
      @(negedge clk);
      checks++;
      if (a_gnt !== 1'b1 || a_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL lat_n1: got a_gnt=%b a_rvalid=%b, required 1 0", a_gnt, a_rvalid);
      end
      a_req = 1'b0;
      @(negedge clk);
      checks++;
      if (a_rvalid !== 1'b1 || a_gnt !== 1'b0) begin
         errors++;
         $display("FAIL lat_n2: got a_rvalid=%b a_gnt=%b, required 1 0", a_rvalid, a_gnt);
      end
      drive(0, 1'b0, 32'd6, '0);
      @(negedge clk);
      checks++;
      if (a_gnt !== 1'b0 || a_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL lat_n3: got a_gnt=%b a_rvalid=%b, required 0 0", a_gnt, a_rvalid);
      end
      @(negedge clk);
      checks++;
      if (a_gnt !== 1'b1) begin
         errors++;
         $display("FAIL lat_n4: got a_gnt=%b, required 1", a_gnt);
      end
      a_req = 1'b0;
      drain("lat");
   endtask

   task automatic test_reset_abort();
      a_req = 1'b1; a_we = 1'b1; a_addr = 32'd3; a_wdata = 32'h12345678;
      wait_gnt(0, "abort");
      checks++;
      if (mem_write !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre: got mem_write=%b, required 1", mem_write);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL abort_outputs: got %h, required 0", outs);
      end
      a_req = 1'b0; a_we = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (mem[3] !== ref_mem[3]) begin
         errors++;
         $display("FAIL abort_mem: got mem[3]=%h, required %h", mem[3], ref_mem[3]);
      end
      drive(0, 1'b0, 32'd3, '0);
      wait_gnt(0, "abort_rd");
      a_req = 1'b0;
      drain("abort");
   endtask

   task automatic test_contention();
      logic [3:0] seq;
      int n;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      seq = 4'b1010;
`else
      seq = 4'b0000;
`endif
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'd5;
      b_req = 1'b1; b_we = 1'b0; b_addr = 32'd9;
      for (int i = 0; i < 4; i++) push_exp(seq[i], 1'b0, seq[i] ? 32'd9 : 32'd5, '0);
      for (int i = 0; i < 4; i++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(a_gnt || b_gnt) && n < 20);
         checks++;
         if (a_gnt === b_gnt || b_gnt !== seq[i]) begin
            errors++;
            $display("FAIL contention_%0d: got a_gnt=%b b_gnt=%b, required b_gnt=%b alone", i, a_gnt, b_gnt, seq[i]);
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      drain("contention");
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] <= 32'(i) * 32'h01010101;
         ref_mem[i] = 32'(i) * 32'h01010101;
      end
      test_reset();
      test_write_read();
      test_out_of_range();
      test_latency();
      test_reset_abort();
      test_contention();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
